// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath constants: register indices used by the register file
// and by the RegDst selector's constant inputs, plus the data word width.
package mips_defs;

  localparam int WORD_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [WORD_W-1:0] SP_INIT_DEFAULT = 32'd227;

  // True when a read index collides with a live write to a real register.
  function automatic logic wr_hit(input logic       we,
                                  input logic [4:0] wreg,
                                  input logic [4:0] rreg);
    return we && (wreg != REG_ZERO) && (wreg == rreg);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: $zero forcing and optional write-through bypass.
module rf_read_port
  import mips_defs::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic [4:0]        idx,
  input  logic [WORD_W-1:0] word,
  input  logic              we,
  input  logic [4:0]        wreg,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] data
);

  // $zero wins over everything, then the in-flight write, then the array.
  always_comb begin
    data = word;
    if (idx == REG_ZERO) begin
      data = '0;
    end else if (BYPASS && wr_hit(we, wreg, idx)) begin
      data = wdata;
    end
  end

endmodule

// File: rtl/banco_reg_wb.sv
// Writeback-stage register file: 32 x 32-bit, $zero hardwired, $sp preset
// at reset, one write port and two combinational read ports.
module banco_reg_wb
  import mips_defs::*;
#(
  parameter logic [WORD_W-1:0] SP_INIT = SP_INIT_DEFAULT,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [WORD_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [WORD_W-1:0] ReadData1,
  output logic [WORD_W-1:0] ReadData2
);

  logic [WORD_W-1:0] regs [0:31];
  logic [WORD_W-1:0] word1;
  logic [WORD_W-1:0] word2;

  // Array update: reset clears everything except $sp; writes to $zero are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[REG_SP] <= SP_INIT;
    end else if (RegWrite && (WriteReg != REG_ZERO)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  assign word1 = regs[ReadReg1];
  assign word2 = regs[ReadReg2];

  rf_read_port #(.BYPASS(BYPASS)) u_port1 (
    .idx   (ReadReg1),
    .word  (word1),
    .we    (RegWrite),
    .wreg  (WriteReg),
    .wdata (WriteData),
    .data  (ReadData1)
  );

  rf_read_port #(.BYPASS(BYPASS)) u_port2 (
    .idx   (ReadReg2),
    .word  (word2),
    .we    (RegWrite),
    .wreg  (WriteReg),
    .wdata (WriteData),
    .data  (ReadData2)
  );

endmodule
